// File: rtl/lock_access_controller.sv
// Shares one combination lock between two keypad panels with round-robin grant and edge-to-pulse keys.
// Defining LOCK_CTRL_LOCKOUT_EN adds failure counting and a timed lockout after MAX_FAILS bad entries.
module lock_access_controller #(
  parameter int MAX_FAILS      = 3,
  parameter int SESSION_CYCLES = 50,
  parameter int OPEN_CYCLES    = 200,
  parameter int LOCKOUT_CYCLES = 100
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ReqA,
  input  logic       ReqB,
  input  logic       KeyA0,
  input  logic       KeyA1,
  input  logic       KeyB0,
  input  logic       KeyB1,
  input  logic [3:0] PasswordA,
  input  logic [3:0] PasswordB,
  input  logic [1:0] LockState,
  output logic       LockKey0,
  output logic       LockKey1,
  output logic [3:0] LockPassword,
  output logic       LockReset,
  output logic       GrantA,
  output logic       GrantB,
  output logic       Unlocked,
  output logic       LockedOut,
  output logic [3:0] FailCount
);

`ifdef LOCK_CTRL_LOCKOUT_EN
  localparam bit LOCKOUT_EN = 1'b1;
`else
  localparam bit LOCKOUT_EN = 1'b0;
`endif

  localparam logic [15:0] SESSION_LIM = 16'(SESSION_CYCLES);
  localparam logic [15:0] OPEN_LIM    = 16'(OPEN_CYCLES);
  localparam logic [15:0] LOCK_LIM    = 16'(LOCKOUT_CYCLES);
  localparam logic [3:0]  FAIL_LIM    = 4'(MAX_FAILS);

  typedef enum logic [2:0] {
    IDLE,
    SESSION,
    OPEN,
    ABORT,
    LOCKOUT
  } state_t;

  state_t      state;
  logic        last_a;
  logic [15:0] timer;
  logic [15:0] timer_inc;
  logic        eval_pend;
  logic [3:0]  fail_next;
  logic        prev_a0, prev_a1, prev_b0, prev_b1;
  logic        rise0, rise1, req_g;
  logic [3:0]  pw_g;
  logic        eval_open, eval_fail;

  assign timer_inc = timer + 16'd1;
  assign fail_next = FailCount + 4'd1;
  assign eval_open = eval_pend && (LockState == 2'b11);
  assign eval_fail = LOCKOUT_EN && eval_pend && (LockState == 2'b00);

  // Only the granted panel's buttons, request and digits are visible to the FSM.
  always_comb begin
    rise0 = 1'b0;
    rise1 = 1'b0;
    req_g = 1'b0;
    pw_g  = 4'd0;
    if (GrantB) begin
      rise0 = KeyB0 & ~prev_b0;
      rise1 = KeyB1 & ~prev_b1;
      req_g = ReqB;
      pw_g  = PasswordB;
    end else begin
      rise0 = KeyA0 & ~prev_a0;
      rise1 = KeyA1 & ~prev_a1;
      req_g = ReqA;
      pw_g  = PasswordA;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      last_a       <= 1'b0;
      timer        <= 16'd0;
      eval_pend    <= 1'b0;
      prev_a0      <= 1'b0;
      prev_a1      <= 1'b0;
      prev_b0      <= 1'b0;
      prev_b1      <= 1'b0;
      LockKey0     <= 1'b0;
      LockKey1     <= 1'b0;
      LockPassword <= 4'd0;
      LockReset    <= 1'b1;
      GrantA       <= 1'b0;
      GrantB       <= 1'b0;
      Unlocked     <= 1'b0;
      LockedOut    <= 1'b0;
      FailCount    <= 4'd0;
    end else begin
      prev_a0   <= KeyA0;
      prev_a1   <= KeyA1;
      prev_b0   <= KeyB0;
      prev_b1   <= KeyB1;
      LockKey0  <= 1'b0;
      LockKey1  <= 1'b0;
      // The lock reacts to a pulse on the following edge, so its state is judged one cycle later.
      eval_pend <= LockKey0 | LockKey1;

      case (state)
        IDLE: begin
          LockReset <= 1'b0;
          timer     <= 16'd0;
          if (ReqA && (!ReqB || !last_a)) begin
            state  <= SESSION;
            GrantA <= 1'b1;
            last_a <= 1'b1;
          end else if (ReqB) begin
            state  <= SESSION;
            GrantB <= 1'b1;
            last_a <= 1'b0;
          end
        end

        SESSION: begin
          if (!req_g || timer_inc == SESSION_LIM) begin
            state     <= ABORT;
            LockReset <= 1'b1;
            GrantA    <= 1'b0;
            GrantB    <= 1'b0;
            timer     <= 16'd0;
          end else if (eval_open) begin
            state     <= OPEN;
            Unlocked  <= 1'b1;
            FailCount <= 4'd0;
            timer     <= 16'd0;
          end else if (eval_fail && fail_next == FAIL_LIM) begin
            state     <= LOCKOUT;
            LockedOut <= 1'b1;
            LockReset <= 1'b1;
            GrantA    <= 1'b0;
            GrantB    <= 1'b0;
            FailCount <= fail_next;
            timer     <= 16'd0;
          end else begin
            if (eval_fail) begin
              FailCount <= fail_next;
            end
            // Both buttons rising together is ambiguous and is dropped without counting.
            if (rise0 ^ rise1) begin
              LockKey0     <= rise0;
              LockKey1     <= rise1;
              LockPassword <= pw_g;
              timer        <= 16'd0;
            end else begin
              timer <= timer_inc;
            end
          end
        end

        OPEN: begin
          if (!req_g || timer_inc == OPEN_LIM) begin
            state     <= ABORT;
            Unlocked  <= 1'b0;
            LockReset <= 1'b1;
            GrantA    <= 1'b0;
            GrantB    <= 1'b0;
            timer     <= 16'd0;
          end else begin
            timer <= timer_inc;
          end
        end

        ABORT: begin
          state     <= IDLE;
          LockReset <= 1'b0;
          timer     <= 16'd0;
        end

        LOCKOUT: begin
          if (timer_inc == LOCK_LIM) begin
            state     <= IDLE;
            LockedOut <= 1'b0;
            LockReset <= 1'b0;
            FailCount <= 4'd0;
            timer     <= 16'd0;
          end else begin
            timer <= timer_inc;
          end
        end

        default: begin
          state     <= IDLE;
          LockReset <= 1'b1;
          GrantA    <= 1'b0;
          GrantB    <= 1'b0;
          Unlocked  <= 1'b0;
          LockedOut <= 1'b0;
          timer     <= 16'd0;
        end
      endcase
    end
  end

endmodule
